// File: rtl/fdtd_mst_pkg.sv
// fdtd_mst_pkg: shared types and AXI constants for the FDTD word master.
package fdtd_mst_pkg;

  // Master FSM states
  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    RSP
  } mst_state_e;

  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // SLVERR and DECERR both have bit 1 set; OKAY/EXOKAY do not
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/axi_bus_if.sv
// AXI_BUS: AXI4 bus bundle with master and slave views.
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter int unsigned AXI_USER_WIDTH = 1
);
  localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_qos;
  logic [3:0]                aw_region;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0]     w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_qos;
  logic [3:0]                ar_region;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );

endinterface

// File: rtl/fdtd_axi_wr_chan.sv
// fdtd_axi_wr_chan: independent AW/W valid tracking for a single-beat write.
// Both valids rise together when the write phase starts; each drops after
// its own handshake, in either order or in the same cycle.
module fdtd_axi_wr_chan (
  input  logic ACLK,
  input  logic ARESETn,
  input  logic start_i,
  input  logic active_i,
  input  logic aw_ready_i,
  input  logic w_ready_i,
  output logic aw_valid_o,
  output logic w_valid_o,
  output logic done_o
);

  logic aw_done;
  logic w_done;
  logic aw_hs;
  logic w_hs;

  assign aw_valid_o = active_i && !aw_done;
  assign w_valid_o  = active_i && !w_done;
  assign aw_hs      = aw_valid_o && aw_ready_i;
  assign w_hs       = w_valid_o && w_ready_i;

  // Both channels finished, counting a handshake that lands this cycle
  assign done_o = active_i && (aw_done || aw_hs) && (w_done || w_hs);

  // Remember which channel has already handshaken in this write phase
  always_ff @(posedge ACLK or negedge ARESETn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!ARESETn) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (start_i) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
    end
  end

endmodule

// File: rtl/fdtd_axi_word_mst.sv
// fdtd_axi_word_mst: single-outstanding AXI4 master turning FDTD word
// requests into single-beat AXI4 reads and writes.
// Optional build macro FDTD_MST_ERR_CNT_EN adds err_cnt_o, a saturating
// count of transactions that completed with SLVERR/DECERR.
module fdtd_axi_word_mst
  import fdtd_mst_pkg::*;
#(
  parameter int unsigned AXI4_ADDR_WIDTH = 32,
  parameter int unsigned AXI4_DATA_WIDTH = 32,
  parameter int unsigned AXI4_ID_WIDTH   = 10,
  parameter int unsigned AXI4_USER_WIDTH = 1,
  parameter int unsigned MST_ID          = 0
) (
  input  logic                         ACLK,
  input  logic                         ARESETn,
  AXI_BUS.Master                       mst,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic                         req_we_i,
  input  logic [AXI4_ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [AXI4_DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [AXI4_DATA_WIDTH/8-1:0] req_strb_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [AXI4_DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                         rsp_err_o,
  output logic                         busy_o
`ifdef FDTD_MST_ERR_CNT_EN
  ,
  output logic [15:0]                  err_cnt_o
`endif
);

  localparam int unsigned STRB_WIDTH = AXI4_DATA_WIDTH / 8;
  localparam int unsigned SIZE       = $clog2(STRB_WIDTH);
  localparam logic [AXI4_ADDR_WIDTH-1:0] ADDR_LSB_MASK = AXI4_ADDR_WIDTH'((1 << SIZE) - 1);

  mst_state_e                 state_q, state_d;
  logic [AXI4_ADDR_WIDTH-1:0] addr_q;
  logic [AXI4_DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0]      strb_q;
  logic [AXI4_DATA_WIDTH-1:0] rdata_q;
  logic                       err_q;
  logic                       accept;
  logic                       wr_done;
  logic                       r_beat;
  logic                       b_beat;

  assign accept = req_valid_i && (state_q == IDLE);
  assign r_beat = (state_q == RD_DATA) && mst.r_valid;
  assign b_beat = (state_q == WR_RESP) && mst.b_valid;

  // Single-beat INCR fields never change
  assign mst.aw_id     = AXI4_ID_WIDTH'(MST_ID);
  assign mst.aw_addr   = addr_q;
  assign mst.aw_len    = 8'd0;
  assign mst.aw_size   = 3'(SIZE);
  assign mst.aw_burst  = BURST_INCR;
  assign mst.aw_lock   = 1'b0;
  assign mst.aw_cache  = 4'd0;
  assign mst.aw_prot   = 3'd0;
  assign mst.aw_qos    = 4'd0;
  assign mst.aw_region = 4'd0;
  assign mst.aw_user   = '0;
  assign mst.w_data    = wdata_q;
  assign mst.w_strb    = strb_q;
  assign mst.w_last    = 1'b1;
  assign mst.w_user    = '0;
  assign mst.ar_id     = AXI4_ID_WIDTH'(MST_ID);
  assign mst.ar_addr   = addr_q;
  assign mst.ar_len    = 8'd0;
  assign mst.ar_size   = 3'(SIZE);
  assign mst.ar_burst  = BURST_INCR;
  assign mst.ar_lock   = 1'b0;
  assign mst.ar_cache  = 4'd0;
  assign mst.ar_prot   = 3'd0;
  assign mst.ar_qos    = 4'd0;
  assign mst.ar_region = 4'd0;
  assign mst.ar_user   = '0;

  // Single outstanding transaction, so IDs, last and user echoes carry no information
  logic unused_rsp_fields;
  assign unused_rsp_fields = ^{mst.r_id, mst.r_last, mst.r_user, mst.r_resp[0],
                               mst.b_id, mst.b_user, mst.b_resp[0]};

  fdtd_axi_wr_chan u_wr_chan (
    .ACLK       (ACLK),
    .ARESETn    (ARESETn),
    .start_i    (accept && req_we_i),
    .active_i   (state_q == WR_REQ),
    .aw_ready_i (mst.aw_ready),
    .w_ready_i  (mst.w_ready),
    .aw_valid_o (mst.aw_valid),
    .w_valid_o  (mst.w_valid),
    .done_o     (wr_done)
  );

  // FSM state register
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state and handshake outputs decoded from the registered state
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
    state_d       = state_q;
    req_ready_o   = 1'b0;
    mst.ar_valid  = 1'b0;
    mst.r_ready   = 1'b0;
    mst.b_ready   = 1'b0;
    rsp_valid_o   = 1'b0;
    busy_o        = 1'b1;
    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (req_valid_i) state_d = req_we_i ? WR_REQ : RD_ADDR;
      end
      RD_ADDR: begin
        mst.ar_valid = 1'b1;
        if (mst.ar_ready) state_d = RD_DATA;
      end
      RD_DATA: begin
        mst.r_ready = 1'b1;
        if (mst.r_valid) state_d = RSP;
      end
      WR_REQ: begin
        if (wr_done) state_d = WR_RESP;
      end
      WR_RESP: begin
        mst.b_ready = 1'b1;
        if (mst.b_valid) state_d = RSP;
      end
      RSP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request payload latched on accept, address forced to word alignment
  always_ff @(posedge ACLK) begin
    // NOTE: payload registers are not reset; they are only observed behind a valid that is.
    if (accept) begin
      addr_q  <= req_addr_i & ~ADDR_LSB_MASK;
      wdata_q <= req_wdata_i;
      strb_q  <= req_strb_i;
    end
  end

  // Response register: read data and error flag held until consumed
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (r_beat) begin
      rdata_q <= mst.r_data;
      err_q   <= resp_is_err(mst.r_resp);
    end else if (b_beat) begin
      rdata_q <= '0;
      err_q   <= resp_is_err(mst.b_resp);
    end
  end

  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

`ifdef FDTD_MST_ERR_CNT_EN
  logic [15:0] err_cnt_q;
  logic        err_evt;

  assign err_evt = (r_beat && resp_is_err(mst.r_resp)) || (b_beat && resp_is_err(mst.b_resp));

  // Saturating count of transactions that ended in an error response
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn)                            err_cnt_q <= 16'd0;
    else if (err_evt && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_fdtd_axi_word_mst.sv
// tb_fdtd_axi_word_mst: directed bench for the FDTD AXI word master with a
// behavioural AXI slave, a reference memory model and a response scoreboard.
// Build with FDTD_MST_ERR_CNT_EN defined to also check err_cnt_o.
module tb_fdtd_axi_word_mst;
  import fdtd_mst_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  AXI_BUS #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(10), .AXI_USER_WIDTH(1)) bus ();

  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [SW-1:0] req_strb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          busy;
`ifdef FDTD_MST_ERR_CNT_EN
  logic [15:0]   err_cnt;
`endif

  fdtd_axi_word_mst #(
    .AXI4_ADDR_WIDTH(AW), .AXI4_DATA_WIDTH(DW), .AXI4_ID_WIDTH(10),
    .AXI4_USER_WIDTH(1), .MST_ID(0)
  ) dut (
    .ACLK        (ACLK),
    .ARESETn     (ARESETn),
    .mst         (bus),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_strb_i  (req_strb),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .busy_o      (busy)
`ifdef FDTD_MST_ERR_CNT_EN
    ,
    .err_cnt_o   (err_cnt)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- memories: slave storage and reference model ----------------
  logic [31:0] smem [logic [31:0]];
  logic [31:0] mdl  [logic [31:0]];

  function automatic logic [31:0] default_word(input logic [31:0] a);
    return a ^ 32'h9E37_79B9;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] smem_rd(input logic [31:0] a);
    return smem.exists(a) ? smem[a] : default_word(a);
  endfunction

  function automatic logic [31:0] mdl_rd(input logic [31:0] a);
    return mdl.exists(a) ? mdl[a] : default_word(a);
  endfunction

  // ---------------- behavioural slave, evaluated on the falling edge ----------------
  int ar_dly = 0, aw_dly = 0, w_dly = 0, r_dly = 0, b_dly = 0;
  logic [1:0] cfg_resp = RESP_OKAY;

  int ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
  logic rd_pend, wr_pend, aw_got, w_got;
  logic [31:0] rd_addr, wr_addr, wr_data;
  logic [3:0]  wr_strb;
  logic [1:0]  wr_resp;
  logic ar_v_q, aw_v_q, w_v_q, r_rdy_q, b_rdy_q;
  logic [31:0] ar_addr_q, aw_addr_q, w_data_q;
  logic [3:0]  w_strb_q;
  logic [31:0] last_ar_addr, last_aw_addr, last_w_data;
  logic [7:0]  last_ar_len;
  logic [2:0]  last_ar_size;
  logic [1:0]  last_ar_burst;
  logic [3:0]  last_w_strb;
  logic        last_w_last;

  always @(negedge ACLK) begin
    if (!ARESETn) begin
      bus.ar_ready = 1'b0; bus.aw_ready = 1'b0; bus.w_ready = 1'b0;
      bus.r_valid = 1'b0; bus.r_data = '0; bus.r_resp = '0; bus.r_last = 1'b0;
      bus.r_id = '0; bus.r_user = '0;
      bus.b_valid = 1'b0; bus.b_resp = '0; bus.b_id = '0; bus.b_user = '0;
      ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
      rd_pend = 1'b0; wr_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0;
      ar_v_q = 1'b0; aw_v_q = 1'b0; w_v_q = 1'b0; r_rdy_q = 1'b0; b_rdy_q = 1'b0;
    end else begin
      // A valid not taken at the last edge must still be up with the same payload
      if (ar_v_q && !bus.ar_ready) check("ar_hold", {bus.ar_valid, bus.ar_addr}, {1'b1, ar_addr_q});
      if (aw_v_q && !bus.aw_ready) check("aw_hold", {bus.aw_valid, bus.aw_addr}, {1'b1, aw_addr_q});
      if (w_v_q && !bus.w_ready)
        check("w_hold", {bus.w_valid, bus.w_data, bus.w_strb}, {1'b1, w_data_q, w_strb_q});

      // Retire handshakes that completed at the preceding rising edge
      if (ar_v_q && bus.ar_ready) begin rd_pend = 1'b1; rd_addr = ar_addr_q; bus.ar_ready = 1'b0; ar_cnt = 0; end
      if (aw_v_q && bus.aw_ready) begin aw_got = 1'b1; wr_addr = aw_addr_q; bus.aw_ready = 1'b0; aw_cnt = 0; end
      if (w_v_q && bus.w_ready) begin
        w_got = 1'b1; wr_data = w_data_q; wr_strb = w_strb_q; bus.w_ready = 1'b0; w_cnt = 0;
      end
      if (bus.r_valid && r_rdy_q) bus.r_valid = 1'b0;
      if (bus.b_valid && b_rdy_q) bus.b_valid = 1'b0;
      if (aw_got && w_got) begin
        if (!cfg_resp[1]) smem[wr_addr] = merge(smem_rd(wr_addr), wr_data, wr_strb);
        aw_got = 1'b0; w_got = 1'b0; wr_pend = 1'b1; wr_resp = cfg_resp;
      end

      // Raise readies / response valids after the configured stalls
      if (bus.ar_valid && !bus.ar_ready) begin
        if (ar_cnt >= ar_dly) begin
          bus.ar_ready = 1'b1;
          last_ar_addr = bus.ar_addr; last_ar_len = bus.ar_len;
          last_ar_size = bus.ar_size; last_ar_burst = bus.ar_burst;
        end else ar_cnt++;
      end
      if (bus.aw_valid && !bus.aw_ready) begin
        if (aw_cnt >= aw_dly) begin bus.aw_ready = 1'b1; last_aw_addr = bus.aw_addr; end
        else aw_cnt++;
      end
      if (bus.w_valid && !bus.w_ready) begin
        if (w_cnt >= w_dly) begin
          bus.w_ready = 1'b1; last_w_data = bus.w_data; last_w_strb = bus.w_strb; last_w_last = bus.w_last;
        end else w_cnt++;
      end
      if (rd_pend && !bus.r_valid) begin
        if (r_cnt >= r_dly) begin
          bus.r_valid = 1'b1; bus.r_data = smem_rd(rd_addr); bus.r_resp = cfg_resp; bus.r_last = 1'b1;
          rd_pend = 1'b0; r_cnt = 0;
        end else r_cnt++;
      end
      if (wr_pend && !bus.b_valid) begin
        if (b_cnt >= b_dly) begin bus.b_valid = 1'b1; bus.b_resp = wr_resp; wr_pend = 1'b0; b_cnt = 0; end
        else b_cnt++;
      end

      ar_v_q = bus.ar_valid; ar_addr_q = bus.ar_addr;
      aw_v_q = bus.aw_valid; aw_addr_q = bus.aw_addr;
      w_v_q = bus.w_valid; w_data_q = bus.w_data; w_strb_q = bus.w_strb;
      r_rdy_q = bus.r_ready; b_rdy_q = bus.b_ready;

      // At most one phase of one transaction is active at any time
      check("one_active",
            32'(bus.ar_valid) + 32'(bus.aw_valid | bus.w_valid) + 32'(bus.r_ready) +
            32'(bus.b_ready) + 32'(rsp_valid) <= 1, 1);
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   exp_err_cnt = 0;

  // Push the expected response, then present the request until accepted
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [1:0] resp);
    exp_t e;
    logic [31:0] a;
    int n;
    a = addr & ~32'h3;
    cfg_resp = resp;
    if (we) begin
      if (!resp[1]) mdl[a] = merge(mdl_rd(a), wdata, strb);
      e.rdata = '0;
    end else begin
      e.rdata = mdl_rd(a);
    end
    e.err = resp[1];
    if (resp[1]) exp_err_cnt++;
    sb.push_back(e);
    req_we = we; req_addr = addr; req_wdata = wdata; req_strb = strb; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge ACLK); n++; end
    check("req_accept_timeout", n < 100, 1);
    @(negedge ACLK);
    req_valid = 1'b0;
  endtask

  // Wait for the response, optionally stall it, then pop and compare
  task automatic collect(input int hold, output int lat);
    exp_t e;
    lat = 1;
    while (!rsp_valid && lat < 200) begin @(negedge ACLK); lat++; end
    check("rsp_timeout", rsp_valid, 1);
    if (rsp_valid && sb.size() > 0) begin
      e = sb.pop_front();
      check("rsp_rdata", rsp_rdata, e.rdata);
      check("rsp_err", rsp_err, e.err);
      for (int k = 0; k < hold; k++) begin
        @(negedge ACLK);
        check("rsp_hold", {rsp_valid, rsp_err, rsp_rdata, req_ready}, {1'b1, e.err, e.rdata, 1'b0});
      end
      rsp_ready = 1'b1;
      @(negedge ACLK);
      rsp_ready = 1'b0;
      check("rsp_consumed", {rsp_valid, busy, req_ready}, 3'b001);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat, n;
    logic [31:0] a, d;
    logic [3:0]  s;
    logic [1:0]  r;

    smem[32'h1A10_0004] = 32'hDEAD_BEEF;
    mdl[32'h1A10_0004]  = 32'hDEAD_BEEF;

    // Reset state
    repeat (3) @(negedge ACLK);
    check("reset_axi_valids", {bus.ar_valid, bus.aw_valid, bus.w_valid, bus.r_ready, bus.b_ready}, 5'b0);
    check("reset_rsp", {rsp_valid, rsp_err, busy}, 3'b000);
    check("reset_rdata", rsp_rdata, 32'h0);
`ifdef FDTD_MST_ERR_CNT_EN
    check("reset_err_cnt", err_cnt, 16'd0);
`endif
    #1 ARESETn = 1'b1;
    @(negedge ACLK);
    check("idle_ready", {req_ready, busy}, 2'b10);

    // Zero-wait read: response three cycles after accept
    issue(1'b0, 32'h1A10_0004, 32'h0, 4'h0, RESP_OKAY);
    check("rd_addr_phase", {busy, bus.ar_valid, bus.r_ready, req_ready}, 4'b1100);
    collect(0, lat);
    check("rd_latency", lat, 3);
    check("ar_addr", last_ar_addr, 32'h1A10_0004);
    check("ar_len_size_burst", {last_ar_len, last_ar_size, last_ar_burst}, {8'd0, 3'd2, 2'b01});

    // Write with W taken three cycles before AW
    aw_dly = 3; w_dly = 0;
    issue(1'b1, 32'h1A10_0008, 32'h1234_5678, 4'b0011, RESP_OKAY);
    check("wr_c1", {bus.aw_valid, bus.w_valid, bus.b_ready}, 3'b110);
    for (int c = 2; c <= 4; c++) begin
      @(negedge ACLK);
      check("wr_w_done_aw_held", {bus.aw_valid, bus.w_valid, bus.b_ready}, 3'b100);
    end
    @(negedge ACLK);
    check("wr_resp_phase", {bus.aw_valid, bus.w_valid, bus.b_ready}, 3'b001);
    collect(0, lat);
    check("aw_addr", last_aw_addr, 32'h1A10_0008);
    check("w_payload", {last_w_data, last_w_strb, last_w_last}, {32'h1234_5678, 4'b0011, 1'b1});
    aw_dly = 0;
    issue(1'b0, 32'h1A10_0008, 32'h0, 4'h0, RESP_OKAY);
    collect(0, lat);

    // DECERR read with the response stalled for five cycles
    issue(1'b0, 32'h1A10_0010, 32'h0, 4'h0, RESP_DECERR);
    collect(5, lat);
`ifdef FDTD_MST_ERR_CNT_EN
    check("err_cnt_after_decerr", err_cnt, 16'd1);
`endif

    // Unaligned read is issued on the containing word
    issue(1'b0, 32'h1A10_0007, 32'h0, 4'h0, RESP_OKAY);
    collect(0, lat);
    check("ar_addr_aligned", last_ar_addr, 32'h1A10_0004);

    // Reset while waiting for read data
    r_dly = 6;
    issue(1'b0, 32'h1A10_000C, 32'h0, 4'h0, RESP_OKAY);
    n = 0;
    while (!bus.r_ready && n < 20) begin @(negedge ACLK); n++; end
    check("reach_rd_data", bus.r_ready, 1);
    #1 ARESETn = 1'b0;
    #1;
    check("reset_mid_txn", {bus.ar_valid, bus.r_ready, rsp_valid, busy, bus.aw_valid, bus.w_valid, bus.b_ready},
          7'b0);
    void'(sb.pop_back());
    exp_err_cnt = 0;
    repeat (2) @(negedge ACLK);
    r_dly = 0;
    #1 ARESETn = 1'b1;
    @(negedge ACLK);
    check("post_reset_idle", {req_ready, busy, rsp_rdata}, {1'b1, 1'b0, 32'h0});
`ifdef FDTD_MST_ERR_CNT_EN
    check("post_reset_err_cnt", err_cnt, 16'd0);
`endif
    issue(1'b1, 32'h1A10_0014, 32'hCAFE_F00D, 4'b1111, RESP_OKAY);
    collect(0, lat);
    issue(1'b0, 32'h1A10_0014, 32'h0, 4'h0, RESP_OKAY);
    collect(0, lat);

    // Back-to-back alternating writes/reads with random stalls and responses
    for (int i = 0; i < 20; i++) begin
      ar_dly = $urandom_range(0, 3); aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
      r_dly  = $urandom_range(0, 3); b_dly  = $urandom_range(0, 3);
      case ($urandom_range(0, 5))
        0:       r = RESP_SLVERR;
        1:       r = RESP_DECERR;
        2:       r = RESP_EXOKAY;
        default: r = RESP_OKAY;
      endcase
      a = 32'h1A10_0100 + 32'((i / 2) % 4) * 4 + 32'($urandom_range(0, 3));
      d = $urandom;
      s = 4'($urandom_range(1, 15));
      issue(i[0] == 1'b0, a, d, s, r);
      collect($urandom_range(0, 2), lat);
    end
    check("scoreboard_empty", sb.size(), 0);
`ifdef FDTD_MST_ERR_CNT_EN
    check("err_cnt_final", err_cnt, 16'(exp_err_cnt));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard stop in case a bounded wait is ever bypassed
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fdtd_axi_word_mst.md
Name: fdtd_axi_word_mst

Overview:
- Single-outstanding AXI4 master. Turns simple word-level read/write requests from FDTD compute logic into single-beat AXI4 transactions.
- Lets the field-update engine fetch and store Hy/Ez words at the addresses programmed through the FDTD register slave.
- Sits between the FDTD datapath and the SoC AXI interconnect, as the initiator counterpart of the register slave's word read/write front-ends.

Parameters:
- AXI4_ADDR_WIDTH, 32, AXI address width; must equal mst.AXI_ADDR_WIDTH.
- AXI4_DATA_WIDTH, 32, AXI data width; must equal mst.AXI_DATA_WIDTH; power of two ≥ 8.
- AXI4_ID_WIDTH, 10, AXI ID width.
- AXI4_USER_WIDTH, 1, AXI user width.
- MST_ID, 0, constant ID driven on aw_id/ar_id.

Ports:
- ACLK  input  1  clock
- ARESETn  input  1  asynchronous active-low reset
- mst  AXI_BUS.Master  -  AXI4 master port; all channels
- req_valid_i  input  1  request valid
- req_ready_o  output  1  request accepted when valid&&ready
- req_we_i  input  1  1 = write, 0 = read
- req_addr_i  input  AXI4_ADDR_WIDTH  byte address
- req_wdata_i  input  AXI4_DATA_WIDTH  write data
- req_strb_i  input  AXI4_DATA_WIDTH/8  write byte strobes
- rsp_valid_o  output  1  response valid
- rsp_ready_i  input  1  response consumed when valid&&ready
- rsp_rdata_o  output  AXI4_DATA_WIDTH  read data (0 for writes)
- rsp_err_o  output  1  1 when RRESP/BRESP is SLVERR or DECERR
- busy_o  output  1  high in every state except IDLE

Behaviour:
- Reset: ARESETn is asynchronous, active-low; ACLK is the clock. All AXI valid/ready outputs = 0. rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0, busy_o = 0. FSM in IDLE. Reset mid-transaction drops all valids immediately; the interconnect is reset together with the block.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RSP.
- req_ready_o = 1 only in IDLE. Request is latched into registers on accept.
- IDLE→RD_ADDR if !we; IDLE→WR_REQ if we.
- Constant AXI fields: len = 0, size = log2(DATA_WIDTH/8), burst = INCR (2'b01), lock/cache/prot/region/qos/user = 0, id = MST_ID, w_last = 1.
- Address alignment: address low log2(DATA_WIDTH/8) bits are forced to 0 on AR/AW.
- RD_ADDR: ar_valid = 1 (registered; first asserted the cycle after accept). It stays stable until ar_ready, then → RD_DATA.
- RD_DATA: r_ready = 1. On r_valid, capture r_data and r_resp[1] as the error flag, then → RSP.
- WR_REQ: aw_valid and w_valid are asserted together in the cycle after accept. Each deasserts independently after its own handshake, tracked by aw_done/w_done flags. Handshakes may occur in either order or in the same cycle. When both are done → WR_RESP.
- WR_RESP: b_ready = 1. On b_valid, capture b_resp[1] as the error flag, set rdata = 0, then → RSP.
- RSP: rsp_valid_o = 1; rdata and err stay stable until rsp_ready_i, then → IDLE.
- Minimum read latency with zero-wait slave: accept at cycle 0, AR handshake at cycle 1, R at cycle 2, rsp_valid_o at cycle 3. A new request can be accepted the cycle after the response is consumed.
- EXOKAY/OKAY give err = 0. r_id/b_id are not checked (single outstanding). Any r_last value is accepted.
- r_ready/b_ready are never asserted outside RD_DATA/WR_RESP.

Optional Feature:
- FDTD_MST_ERR_CNT_EN: when defined, adds output port err_cnt_o [15:0].
- err_cnt_o increments on each completed transaction with err = 1, saturates at 16'hFFFF, and resets to 0.
- When not defined, the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package fdtd_mst_pkg holds:
  - FSM state enum type;
  - AXI constants BURST_INCR = 2'b01, RESP_OKAY/EXOKAY/SLVERR/DECERR.
- Sub-module fdtd_axi_wr_chan implements the independent AW/W valid tracking (aw_done/w_done). The top holds the FSM and response register.

Test Plan:
- Read, zero-wait slave, addr 0x1A10_0004 returning 0xDEAD_BEEF/OKAY → AR addr 0x1A10_0004, len 0, size 2. rsp_valid_o at cycle 3, rsp_rdata_o = 0xDEADBEEF, rsp_err_o = 0.
- Write 0x1234_5678 strb 4'b0011 to 0x1A10_0008; slave asserts w_ready 3 cycles before aw_ready → w_valid drops after its handshake, aw_valid holds until its own. b_ready only afterwards; rsp_err_o = 0, rsp_rdata_o = 0.
- Read returns DECERR; rsp_ready_i held low 5 cycles → rsp_valid_o, rsp_err_o = 1 and rdata stable for 5 cycles. req_ready_o = 0 throughout. With FDTD_MST_ERR_CNT_EN, err_cnt_o = 1.
- Unaligned read at 0x1A10_0007 → ar_addr = 0x1A10_0004.
- ARESETn asserted while in RD_DATA → ar_valid/r_ready/rsp_valid_o/busy_o = 0 immediately. After release, a fresh write completes normally.
- 20 back-to-back alternating read/write requests with random slave stalls → every response matches in order. No valid drops before its handshake; never more than one transaction outstanding.
